// File: rtl/ysyx_23060077_rd_arbiter_pkg.sv
// Shared widths, AXI encodings, requester IDs and FSM state encodings for the
// Icache/LSU read-channel arbiter.
package ysyx_23060077_rd_arbiter_pkg;

  localparam int unsigned AXI_ADDR_WIDTH = 32;
  localparam int unsigned AXI_LEN_WIDTH  = 8;
  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned AXI_ID_WIDTH   = 4;
  localparam int unsigned AXI_SIZE_WIDTH = 3;

  // Consecutive LSU grants allowed while the Icache is waiting.
  localparam int unsigned STARVE_MAX = 2;
  localparam int unsigned STARVE_W   = 2;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam logic [AXI_ID_WIDTH-1:0]   IC_ID     = 4'd0;
  localparam logic [AXI_ID_WIDTH-1:0]   LSU_ID    = 4'd1;
  localparam logic [AXI_SIZE_WIDTH-1:0] IC_ARSIZE = 3'b010;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  // Latched AR payload for the outstanding transaction.
  typedef struct packed {
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_LEN_WIDTH-1:0]  len;
    logic [AXI_SIZE_WIDTH-1:0] size;
  } ar_req_t;

endpackage

// File: rtl/ysyx_23060077_rd.sv
// Read-channel arbiter top is ysyx_23060077_rd_arbiter in rtl/ysyx_23060077_rd_arbiter.sv.

// File: rtl/ysyx_23060077_rd_grant.sv
// Priority picker between Icache and LSU with an anti-starvation counter.
// Ports: clock/reset (sync, active-high); ic_valid, lsu_valid requests;
// grant (a pick is being taken this cycle); pick_lsu_c / pick_ic_c are the
// combinational winner strobes.
module ysyx_23060077_rd_grant
  import ysyx_23060077_rd_arbiter_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic ic_valid,
  input  logic lsu_valid,
  input  logic grant,
  output logic pick_lsu_c,
  output logic pick_ic_c
);

  logic [STARVE_W-1:0] starve_cnt_q;
  logic                starved;

  // LSU normally wins; once the Icache has been passed over STARVE_MAX times it takes the slot.
  assign starved    = ic_valid && (starve_cnt_q == STARVE_W'(STARVE_MAX));
  assign pick_lsu_c = lsu_valid && !starved;
  assign pick_ic_c  = ic_valid && !pick_lsu_c;

  // Count only LSU grants that bypassed a waiting Icache; anything else clears.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else if (grant) begin
      if (pick_lsu_c && ic_valid) begin
        starve_cnt_q <= starve_cnt_q + STARVE_W'(1);
      end else begin
        starve_cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/ysyx_23060077_rd_arbiter.sv
// Shares one AXI4 read channel (AR/R) between the Icache refill port and the
// LSU load port. One burst outstanding; grant held until RLAST.
// Ports: clock/reset (sync, active-high); ic_* Icache request/beat ports;
// lsu_* LSU request/beat ports; rd_err_o beat error pulse; ar*/r* AXI master.
module ysyx_23060077_rd_arbiter
  import ysyx_23060077_rd_arbiter_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ic_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0] ic_addr_i,
  input  logic [AXI_LEN_WIDTH-1:0]  ic_len_i,
  output logic                      ic_ready_o,
  output logic [DATA_WIDTH-1:0]     ic_data_o,
  output logic                      ic_last_o,
  input  logic                      lsu_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [2:0]                lsu_size_i,
  output logic                      lsu_ready_o,
  output logic [DATA_WIDTH-1:0]     lsu_data_o,
  output logic                      lsu_last_o,
  output logic                      rd_err_o,
  output logic                      arvalid_o,
  input  logic                      arready_i,
  output logic [AXI_ADDR_WIDTH-1:0] araddr_o,
  output logic [3:0]                arid_o,
  output logic [AXI_LEN_WIDTH-1:0]  arlen_o,
  output logic [2:0]                arsize_o,
  output logic [1:0]                arburst_o,
  input  logic                      rvalid_i,
  output logic                      rready_o,
  input  logic [DATA_WIDTH-1:0]     rdata_i,
  input  logic [1:0]                rresp_i,
  input  logic                      rlast_i,
  input  logic [3:0]                rid_i
);

  logic [1:0]               state_q, state_d;
  ar_req_t                  ar_q, ar_d;
  logic                     arvalid_q, arvalid_d;
  logic                     rready_q, rready_d;
  logic                     owner_lsu_q, owner_lsu_d;
  logic [AXI_LEN_WIDTH-1:0] beat_q, beat_d;
  logic                     pick_lsu, pick_ic, grant, beat_fire;

  assign grant = (state_q == ST_IDLE) && (pick_lsu || pick_ic);

  ysyx_23060077_rd_grant u_grant (
    .clock      (clock),
    .reset      (reset),
    .ic_valid   (ic_valid_i),
    .lsu_valid  (lsu_valid_i),
    .grant      (grant),
    .pick_lsu_c (pick_lsu),
    .pick_ic_c  (pick_ic)
  );

  // State and registered AXI control.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ar_q        <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      owner_lsu_q <= 1'b0;
      beat_q      <= '0;
    end else begin
      state_q     <= state_d;
      ar_q        <= ar_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      owner_lsu_q <= owner_lsu_d;
      beat_q      <= beat_d;
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    state_d     = state_q;
    ar_d        = ar_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    owner_lsu_d = owner_lsu_q;
    beat_d      = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d     = ST_ADDR;
          arvalid_d   = 1'b1;
          owner_lsu_d = pick_lsu;
          if (pick_lsu) begin
            ar_d.addr = lsu_addr_i;
            ar_d.id   = LSU_ID;
            ar_d.len  = '0;
            ar_d.size = lsu_size_i;
          end else begin
            ar_d.addr = ic_addr_i;
            ar_d.id   = IC_ID;
            ar_d.len  = ic_len_i;
            ar_d.size = IC_ARSIZE;
          end
        end
      end
      ST_ADDR: begin
        if (arready_i) begin
          state_d   = ST_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          beat_d    = '0;
        end
      end
      ST_DATA: begin
        if (rvalid_i) begin
          beat_d = beat_q + AXI_LEN_WIDTH'(1);
          // Termination follows RLAST only, even when it arrives at the wrong beat.
          if (rlast_i) begin
            state_d  = ST_IDLE;
            rready_d = 1'b0;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
      end
    endcase
  end

  assign beat_fire = (state_q == ST_DATA) && rready_q && rvalid_i;

  // Beats are forwarded to the latched owner in the same cycle they arrive.
  assign ic_ready_o  = beat_fire && !owner_lsu_q;
  assign ic_data_o   = ic_ready_o ? rdata_i : '0;
  assign ic_last_o   = ic_ready_o && rlast_i;
  assign lsu_ready_o = beat_fire && owner_lsu_q;
  assign lsu_data_o  = lsu_ready_o ? rdata_i : '0;
  assign lsu_last_o  = lsu_ready_o && rlast_i;

  // RLAST must coincide exactly with the beat whose count equals ARLEN.
  assign rd_err_o = beat_fire && ((rresp_i != AXI_RESP_OKAY) || (rid_i != ar_q.id) ||
                                  (rlast_i != (beat_q == ar_q.len)));

  assign arvalid_o = arvalid_q;
  assign araddr_o  = ar_q.addr;
  assign arid_o    = ar_q.id;
  assign arlen_o   = ar_q.len;
  assign arsize_o  = ar_q.size;
  assign arburst_o = AXI_BURST_INCR;
  assign rready_o  = rready_q;

endmodule

// File: tb/tb_ysyx_23060077_rd_arbiter.sv
// Scoreboard bench for the read-channel arbiter: stimulus pushes expected AR
// requests and R beats into queues; a negedge monitor pops and compares them.
module tb_ysyx_23060077_rd_arbiter;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [2:0]  size;
  } ar_exp_t;

  typedef struct packed {
    logic        is_lsu;
    logic [31:0] data;
    logic        last;
    logic        err;
  } beat_exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        ic_valid_i, lsu_valid_i, arready_i, rvalid_i, rlast_i;
  logic [31:0] ic_addr_i, lsu_addr_i, rdata_i;
  logic [7:0]  ic_len_i;
  logic [2:0]  lsu_size_i;
  logic [1:0]  rresp_i;
  logic [3:0]  rid_i;
  logic        ic_ready_o, ic_last_o, lsu_ready_o, lsu_last_o, rd_err_o;
  logic [31:0] ic_data_o, lsu_data_o, araddr_o;
  logic        arvalid_o, rready_o;
  logic [3:0]  arid_o;
  logic [7:0]  arlen_o;
  logic [2:0]  arsize_o;
  logic [1:0]  arburst_o;

  int checks = 0;
  int errors = 0;
  ar_exp_t   ar_q[$];
  beat_exp_t beat_q[$];

  always #5 clock = ~clock;

  ysyx_23060077_rd_arbiter dut (
    .clock(clock), .reset(reset),
    .ic_valid_i(ic_valid_i), .ic_addr_i(ic_addr_i), .ic_len_i(ic_len_i),
    .ic_ready_o(ic_ready_o), .ic_data_o(ic_data_o), .ic_last_o(ic_last_o),
    .lsu_valid_i(lsu_valid_i), .lsu_addr_i(lsu_addr_i), .lsu_size_i(lsu_size_i),
    .lsu_ready_o(lsu_ready_o), .lsu_data_o(lsu_data_o), .lsu_last_o(lsu_last_o),
    .rd_err_o(rd_err_o),
    .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o),
    .arid_o(arid_o), .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o),
    .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i),
    .rresp_i(rresp_i), .rlast_i(rlast_i), .rid_i(rid_i)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: AR handshakes and R beats are matched against the queues.
  always @(negedge clock) begin
    if (!reset) begin
      if (arvalid_o && arready_i) begin
        ar_exp_t got;
        got = '{addr: araddr_o, id: arid_o, len: arlen_o, size: arsize_o};
        checks++;
        if (ar_q.size() == 0) begin
          errors++;
          $display("FAIL ar_unexpected: got %h expected none", got);
        end else begin
          ar_exp_t e;
          e = ar_q.pop_front();
          if (got !== e || arburst_o !== 2'b01) begin
            errors++;
            $display("FAIL ar_req: got addr=%h id=%0d len=%0d size=%0d burst=%b expected addr=%h id=%0d len=%0d size=%0d burst=01",
                     got.addr, got.id, got.len, got.size, arburst_o, e.addr, e.id, e.len, e.size);
          end
        end
      end
      if (ic_ready_o || lsu_ready_o) begin
        beat_exp_t got;
        got.is_lsu = lsu_ready_o;
        got.data   = lsu_ready_o ? lsu_data_o : ic_data_o;
        got.last   = lsu_ready_o ? lsu_last_o : ic_last_o;
        got.err    = rd_err_o;
        checks++;
        if (ic_ready_o && lsu_ready_o) begin
          errors++;
          $display("FAIL beat_owner: got both ready expected one");
        end else if (beat_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got %h expected none", got);
        end else begin
          beat_exp_t e;
          e = beat_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL beat: got lsu=%b data=%h last=%b err=%b expected lsu=%b data=%h last=%b err=%b",
                     got.is_lsu, got.data, got.last, got.err, e.is_lsu, e.data, e.last, e.err);
          end
        end
      end else if (rd_err_o) begin
        checks++;
        errors++;
        $display("FAIL stray_err: got rd_err_o=1 expected 0 without a beat");
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic push_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] sz);
    ar_q.push_back('{addr: a, id: id, len: len, size: sz});
  endtask

  task automatic ar_handshake(input int delay);
    int n = 0;
    while (!arvalid_o && n < 20) begin
      tick();
      n++;
    end
    check("arvalid_wait", 64'(arvalid_o), 64'd1);
    repeat (delay) tick();
    arready_i = 1'b1;
    tick();
    arready_i = 1'b0;
  endtask

  // Drives one R beat and records what the owner should see.
  task automatic beat(input logic lsu, input logic [31:0] d, input logic last,
                      input logic [1:0] resp, input logic [3:0] id, input logic err);
    int n = 0;
    while (!rready_o && n < 20) begin
      tick();
      n++;
    end
    check("rready_wait", 64'(rready_o), 64'd1);
    beat_q.push_back('{is_lsu: lsu, data: d, last: last, err: err});
    rvalid_i = 1'b1; rdata_i = d; rlast_i = last; rresp_i = resp; rid_i = id;
    tick();
    rvalid_i = 1'b0; rdata_i = '0; rlast_i = 1'b0; rresp_i = 2'b00; rid_i = '0;
  endtask

  initial begin
    reset = 1'b1;
    ic_valid_i = 0; lsu_valid_i = 0; arready_i = 0; rvalid_i = 0; rlast_i = 0;
    ic_addr_i = '0; lsu_addr_i = '0; rdata_i = '0; ic_len_i = '0; lsu_size_i = '0;
    rresp_i = '0; rid_i = '0;
    tick(); tick();
    check("rst_arvalid", 64'(arvalid_o), 64'd0);
    check("rst_rready", 64'(rready_o), 64'd0);
    check("rst_ar_fields", {araddr_o, arid_o, arlen_o, arsize_o}, 64'd0);
    check("rst_arburst", 64'(arburst_o), 64'd1);
    check("rst_beat_outs", {ic_ready_o, lsu_ready_o, ic_last_o, lsu_last_o, rd_err_o}, 64'd0);
    reset = 1'b0;

    // Icache-only burst of 4, arready two cycles late.
    ic_valid_i = 1; ic_addr_i = 32'h3000_0000; ic_len_i = 8'd3;
    check("ic_lat_pre", 64'(arvalid_o), 64'd0);
    tick();
    check("ic_lat_arvalid", 64'(arvalid_o), 64'd1);
    check("ic_arlen", 64'(arlen_o), 64'd3);
    check("ic_arid", 64'(arid_o), 64'd0);
    push_ar(32'h3000_0000, 4'd0, 8'd3, 3'b010);
    ar_handshake(2);
    for (int i = 0; i < 4; i++) beat(0, 32'hA000_0000 + 32'(i), i == 3, 2'b00, 4'd0, 0);
    ic_valid_i = 0;
    check("ic_done_rready", 64'(rready_o), 64'd0);

    // Simultaneous requests: LSU first, Icache right after LSU's last beat.
    lsu_valid_i = 1; lsu_addr_i = 32'h8000_0010; lsu_size_i = 3'd2;
    ic_valid_i = 1; ic_addr_i = 32'h3000_0040; ic_len_i = 8'd1;
    push_ar(32'h8000_0010, 4'd1, 8'd0, 3'd2);
    ar_handshake(0);
    beat(1, 32'h1234_5678, 1, 2'b00, 4'd1, 0);
    lsu_valid_i = 0;
    check("both_idle_gap", 64'(arvalid_o), 64'd0);
    tick();
    check("both_ic_next", {63'(arvalid_o), 1'b0} | 64'(arid_o), {63'd1, 1'b0} | 64'd0);
    push_ar(32'h3000_0040, 4'd0, 8'd1, 3'b010);
    ar_handshake(0);
    beat(0, 32'hB000_0000, 0, 2'b00, 4'd0, 0);
    beat(0, 32'hB000_0001, 1, 2'b00, 4'd0, 0);
    ic_valid_i = 0;

    // Starvation: LSU, LSU, Icache, LSU.
    ic_valid_i = 1; ic_addr_i = 32'h3000_0080; ic_len_i = 8'd0;
    lsu_valid_i = 1; lsu_addr_i = 32'h8000_0020; lsu_size_i = 3'd1;
    for (int i = 0; i < 2; i++) begin
      push_ar(32'h8000_0020, 4'd1, 8'd0, 3'd1);
      ar_handshake(0);
      beat(1, 32'hC000_0000 + 32'(i), 1, 2'b00, 4'd1, 0);
    end
    check("starve_at_max", 64'(dut.u_grant.starve_cnt_q), 64'd2);
    push_ar(32'h3000_0080, 4'd0, 8'd0, 3'b010);
    ar_handshake(0);
    check("starve_cleared", 64'(dut.u_grant.starve_cnt_q), 64'd0);
    beat(0, 32'hC100_0000, 1, 2'b00, 4'd0, 0);
    ic_valid_i = 0;
    push_ar(32'h8000_0020, 4'd1, 8'd0, 3'd1);
    ar_handshake(0);
    beat(1, 32'hC000_0002, 1, 2'b00, 4'd1, 0);
    lsu_valid_i = 0;

    // Early RLAST on beat 2 of a 4-beat burst.
    ic_valid_i = 1; ic_addr_i = 32'h3000_0100; ic_len_i = 8'd3;
    push_ar(32'h3000_0100, 4'd0, 8'd3, 3'b010);
    ar_handshake(1);
    beat(0, 32'hD000_0000, 0, 2'b00, 4'd0, 0);
    beat(0, 32'hD000_0001, 1, 2'b00, 4'd0, 1);
    ic_valid_i = 0;
    check("early_last_released", 64'(rready_o), 64'd0);
    tick();
    check("early_last_idle", 64'(arvalid_o), 64'd0);

    // Bad RRESP and bad RID beats are flagged but still forwarded.
    ic_valid_i = 1; ic_addr_i = 32'h3000_0200; ic_len_i = 8'd3;
    push_ar(32'h3000_0200, 4'd0, 8'd3, 3'b010);
    ar_handshake(0);
    beat(0, 32'hE000_0000, 0, 2'b10, 4'd0, 1);
    beat(0, 32'hE000_0001, 0, 2'b00, 4'd1, 1);
    beat(0, 32'hE000_0002, 0, 2'b00, 4'd0, 0);
    beat(0, 32'hE000_0003, 1, 2'b00, 4'd0, 0);
    ic_valid_i = 0;

    // Reset after one beat of a 4-beat burst.
    ic_valid_i = 1; ic_addr_i = 32'h3000_0300; ic_len_i = 8'd3;
    push_ar(32'h3000_0300, 4'd0, 8'd3, 3'b010);
    ar_handshake(0);
    beat(0, 32'hF000_0000, 0, 2'b00, 4'd0, 0);
    ic_valid_i = 0;
    reset = 1'b1;
    rvalid_i = 1'b1; rdata_i = 32'hF000_0001;
    tick();
    check("rst_mid_arvalid", 64'(arvalid_o), 64'd0);
    check("rst_mid_rready", 64'(rready_o), 64'd0);
    check("rst_mid_ready_outs", {ic_ready_o, lsu_ready_o}, 64'd0);
    check("rst_mid_state", 64'(dut.state_q), 64'd0);
    rvalid_i = 1'b0; rdata_i = '0;
    reset = 1'b0;
    lsu_valid_i = 1; lsu_addr_i = 32'h8000_0040; lsu_size_i = 3'd2;
    tick();
    check("post_rst_grant", {63'(arvalid_o), 1'b0} | 64'(arid_o), {63'd1, 1'b0} | 64'd1);
    push_ar(32'h8000_0040, 4'd1, 8'd0, 3'd2);
    ar_handshake(0);
    beat(1, 32'h5555_AAAA, 1, 2'b00, 4'd1, 0);
    lsu_valid_i = 0;

    repeat (3) tick();
    check("ar_queue_empty", 64'(ar_q.size()), 64'd0);
    check("beat_queue_empty", 64'(beat_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060077_rd_arbiter.md
Name: ysyx_23060077_rd_arbiter

Overview:
- Shares the single AXI4 read channel (AR/R) between the Icache refill port and the LSU load port.
- Sits between the Icache/LSU and the SoC crossbar master.
- Grants one requester at a time and holds the grant for a full burst, until RLAST.
- Sequences AR issue and R-beat return, and checks burst length and ID.

Parameters:
- ADDR_W, 32, AXI address width
- DATA_W, 32, AXI data width (one instruction/word per beat)
- LEN_W, 8, AXI burst length field width
- IC_ID, 4'd0, ARID used for Icache bursts
- LSU_ID, 4'd1, ARID used for LSU reads
- STARVE_MAX, 2, max consecutive LSU grants while Icache is waiting

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- ic_valid_i  in  1  Icache read request; held until its last beat
- ic_addr_i  in  ADDR_W  Icache burst start address
- ic_len_i  in  LEN_W  Icache burst length minus 1
- ic_ready_o  out  1  beat strobe to Icache
- ic_data_o  out  DATA_W  beat data
- ic_last_o  out  1  final beat of the Icache burst
- lsu_valid_i  in  1  LSU read request; held until its beat
- lsu_addr_i  in  ADDR_W  LSU address
- lsu_size_i  in  3  AXI ARSIZE for the load
- lsu_ready_o  out  1  beat strobe to LSU
- lsu_data_o  out  DATA_W  beat data
- lsu_last_o  out  1  final beat of the LSU read
- rd_err_o  out  1  one-cycle pulse on RRESP!=OKAY, RID mismatch, or RLAST at the wrong beat
- arvalid_o  out  1  AXI AR valid
- arready_i  in  1  AXI AR ready
- araddr_o  out  ADDR_W  AXI AR address
- arid_o  out  4  AXI AR id
- arlen_o  out  LEN_W  AXI AR length
- arsize_o  out  3  AXI AR size
- arburst_o  out  2  AXI AR burst type
- rvalid_i  in  1  AXI R valid
- rready_o  out  1  AXI R ready
- rdata_i  in  DATA_W  AXI R data
- rresp_i  in  2  AXI R response
- rlast_i  in  1  AXI R last
- rid_i  in  4  AXI R id

Behaviour:
- Reset values (reset is synchronous, active-high; clock is clock):
  - state=IDLE, owner=none, beat_cnt=0, starve_cnt=0.
  - All outputs 0, except arburst_o = 2'b01 (INCR) constant.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any valid is high, grant one, latch addr/len/size/id into AR registers, go to ADDR next cycle.
  - Request-to-arvalid latency is 1 cycle.
- Grant rule:
  - LSU wins when both are valid, unless starve_cnt==STARVE_MAX; then Icache wins.
  - starve_cnt increments on an LSU grant while ic_valid_i is high.
  - starve_cnt clears on any Icache grant, or when ic_valid_i is low at grant time.
- Latched AR values:
  - Icache: arlen=ic_len_i, arsize=3'b010.
  - LSU: arlen=0, arsize=lsu_size_i.
- ADDR:
  - arvalid_o=1 with AR fields stable until arready_i.
  - On the handshake cycle: arvalid_o drops next cycle, go to DATA, beat_cnt=0.
- DATA:
  - rready_o=1.
  - Each rvalid_i beat is passed through combinationally to the owner: owner ready=rvalid_i, data=rdata_i, last=rlast_i. The non-owner sees ready=0.
  - beat_cnt increments per beat.
  - On the rlast_i beat: release the grant, return to IDLE. A new grant is possible the following cycle, with no dead cycle beyond IDLE.
- Error checks (rd_err_o pulses in the same cycle as the offending beat):
  - rresp_i!=0
  - rid_i!=arid_o
  - rlast_i asserted with beat_cnt!=arlen_o
  - beat_cnt==arlen_o without rlast_i
- Error handling: on error the beat is still forwarded. Burst termination follows rlast_i only.
- Requests arriving during ADDR/DATA wait. No preemption.
- Valid dropping early is a protocol violation by the requester. The latched request still completes, with beats forwarded to the latched owner.
- Reset mid-burst: immediate return to IDLE, arvalid_o/rready_o low next edge, outstanding burst abandoned (slave is reset with the same signal).
- Only one transaction is outstanding at any time.

Decomposition:
- Shared define file: AXI_ADDR_WIDTH, AXI_LEN_WIDTH, DATA_WIDTH, AXI burst/resp encodings (INCR=2'b01, OKAY=2'b00), requester ID constants, state encodings.
- One natural sub-module: ysyx_23060077_rd_grant, a combinational priority/starvation picker plus the starve_cnt register.

Test Plan:
- Icache only, addr 0x3000_0000, len 3, arready after 2 cycles, 4 beats with last on 4th:
  - arvalid_o 1 cycle after request, arlen_o=3, arid_o=0.
  - ic_ready_o pulses 4×, ic_last_o on 4th.
  - Back to IDLE, rd_err_o never pulses.
- Simultaneous ic_valid_i and lsu_valid_i, LSU addr 0x8000_0010, size 2:
  - LSU granted first (arid_o=1, arlen_o=0).
  - Icache granted the cycle after LSU rlast returns to IDLE.
- LSU requests back-to-back 3× while Icache is held valid:
  - Grant order is LSU, LSU, Icache, LSU.
  - starve_cnt resets after the Icache grant.
- Icache burst len 3 with rlast_i on 2nd beat:
  - rd_err_o pulses on beat 2, grant released, FSM to IDLE.
- Beat with rresp_i=2'b10 or rid_i=1 during an Icache burst:
  - rd_err_o pulses that cycle, data still forwarded to Icache.
- Reset asserted in DATA after 1 of 4 beats:
  - Next cycle arvalid_o=0, rready_o=0, ready outputs 0, state IDLE.
  - A new request after reset is granted normally.
